// File: rtl/uart_rxbuf_pkg.sv
// Shared types for the UART receive buffer: FIFO entry layout, error-tracking
// states and the occupancy-width helper.
package uart_rxbuf_pkg;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rxbuf_entry_t;

    typedef enum logic {
        F_CLEAN = 1'b0,
        F_DIRTY = 1'b1
    } rxbuf_fsm_t;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; head is forced to zero while empty.
// Full/empty are derived from the occupancy count, pointers wrap naturally.
module uart_sync_fifo
    import uart_rxbuf_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = rxbuf_entry_t
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  T                            din,
    output T                            head,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_en;
    logic          wr_en;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign rd_en = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);
    assign head  = empty ? T'('0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: rx_done edge capture, sticky per-frame error tag,
// error counter and overflow flag. Define UART_RXBUF_DROP_ERR_EN to discard error frames.
//
// state   | meaning
// F_CLEAN | no receiver error seen since the last captured frame
// F_DIRTY | an error was seen; the next captured frame is tagged
module uart_rx_buffer
    import uart_rxbuf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_done,
    input  logic                        rx_err,
    input  logic                        m_ready,
    output logic                        m_valid,
    output logic [7:0]                  m_data,
    output logic                        m_frame_err,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic [CNT_W-1:0]            err_cnt
);

    rxbuf_fsm_t   state;
    logic         rx_done_q;
    logic         push_ev;
    logic         tag;
    logic         store_ev;
    logic         pop_fire;
    logic         accept;
    logic         drop;
    logic         count_ev;
    logic         empty;
    rxbuf_entry_t din;
    rxbuf_entry_t head;

    assign push_ev  = rx_done & ~rx_done_q;
    assign tag      = (state == F_DIRTY) | rx_err;
    assign pop_fire = m_ready & ~empty;

`ifdef UART_RXBUF_DROP_ERR_EN
    // Error frames never reach the FIFO, so they cannot cause an overflow.
    assign store_ev    = push_ev & ~tag;
    assign count_ev    = push_ev & tag;
    assign m_frame_err = 1'b0;
    logic unused_head_err;
    assign unused_head_err = head.err;
`else
    assign store_ev    = push_ev;
    assign count_ev    = accept & tag;
    assign m_frame_err = head.err;
`endif

    assign accept  = store_ev & (~full | pop_fire);
    assign drop    = store_ev & full & ~pop_fire;
    assign din     = '{err: tag, data: rx_data};
    assign m_valid = ~empty;
    assign m_data  = head.data;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (rxbuf_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (store_ev),
        .pop   (m_ready),
        .din   (din),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= F_CLEAN;
        end else begin
            case (state)
                F_CLEAN: if (!push_ev && rx_err) state <= F_DIRTY;
                F_DIRTY: if (push_ev)            state <= F_CLEAN;
                default:                         state <= F_CLEAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b0;
            overflow  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            rx_done_q <= rx_done;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (count_ev && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized and directed bench for uart_rx_buffer against a queue-based model.
module tb_uart_rx_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             rx_err;
    logic             m_ready;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_frame_err;
    logic [LW-1:0]    level;
    logic             full;
    logic             overflow;
    logic             ovf_clr;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    logic [8:0] q[$];
    bit         m_dirty;
    bit         m_prev_done;
    bit         m_ovf;
    int         m_cnt;

    always #5 clk = ~clk;

    uart_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_frame_err (m_frame_err),
        .level       (level),
        .full        (full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .err_cnt     (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model(input bit d, input logic [7:0] dat, input bit e,
                         input bit rdy, input bit oc, input bit r);
        bit push, pop, tag, store, acc, drop;
        if (r) begin
            q.delete();
            m_dirty = 0; m_prev_done = 0; m_ovf = 0; m_cnt = 0;
            return;
        end
        push  = d && !m_prev_done;
        pop   = rdy && (q.size() > 0);
        tag   = m_dirty || e;
`ifdef UART_RXBUF_DROP_ERR_EN
        store = push && !tag;
`else
        store = push;
`endif
        acc   = store && ((q.size() < DEPTH) || pop);
        drop  = store && !acc;
`ifdef UART_RXBUF_DROP_ERR_EN
        if (push && tag && m_cnt < 255) m_cnt++;
`else
        if (acc && tag && m_cnt < 255) m_cnt++;
`endif
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({tag, dat});
        if (drop) m_ovf = 1;
        else if (oc) m_ovf = 0;
        if (push) m_dirty = 0;
        else if (e) m_dirty = 1;
        m_prev_done = d;
    endtask

    task automatic compare_all();
        logic [8:0] hd;
        hd = (q.size() > 0) ? q[0] : 9'h0;
        chk("m_valid",     {31'd0, m_valid},     {31'd0, q.size() > 0});
        chk("m_data",      {24'd0, m_data},      {24'd0, hd[7:0]});
        chk("m_frame_err", {31'd0, m_frame_err}, {31'd0, hd[8]});
        chk("level",       32'(level),           32'(q.size()));
        chk("full",        {31'd0, full},        {31'd0, q.size() == DEPTH});
        chk("overflow",    {31'd0, overflow},    {31'd0, m_ovf});
        chk("err_cnt",     32'(err_cnt),         32'(m_cnt));
    endtask

    task automatic step(input bit d, input logic [7:0] dat, input bit e,
                        input bit rdy, input bit oc, input bit r);
        rx_done = d; rx_data = dat; rx_err = e; m_ready = rdy; ovf_clr = oc; rst = r;
        @(posedge clk);
        model(d, dat, e, rdy, oc, r);
        #1;
        compare_all();
    endtask

    task automatic frame(input logic [7:0] dat, input bit e, input bit rdy);
        step(1, dat, e, rdy, 0, 0);
        step(0, 8'h00, 0, rdy, 0, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, rdy, 0, 0);
    endtask

    initial begin
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("reset_level", 32'(level), 0);

        // single clean frame
        step(1, 8'hA5, 0, 0, 0, 0);
        chk("a5_data", {24'd0, m_data}, 32'hA5);
        chk("a5_level", 32'(level), 1);
        step(0, 8'h00, 0, 1, 0, 0);
        chk("a5_drained", {31'd0, m_valid}, 0);

        // error earlier in the frame, then clean-up
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, 0);
        idle(10, 0);
        frame(8'h3C, 0, 0);
        chk("3c_cnt", 32'(err_cnt), 1);
`ifndef UART_RXBUF_DROP_ERR_EN
        chk("3c_tag", {31'd0, m_frame_err}, 1);
`endif
        idle(1, 1);
        frame(8'h11, 0, 0);
        chk("11_tag", {31'd0, m_frame_err}, 0);
        idle(2, 1);

        // fill, overflow, drain, clear
        for (int i = 0; i < 8; i++) frame(8'(i), 0, 0);
        chk("fill_full", {31'd0, full}, 1);
        frame(8'hFF, 0, 0);
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("ovf_level", 32'(level), 8);
        idle(10, 1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("ovf_clr", {31'd0, overflow}, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) frame(8'h20 + 8'(i), 0, 0);
        step(1, 8'h55, 0, 1, 0, 0);
        chk("pp_level", 32'(level), 8);
        chk("pp_ovf", {31'd0, overflow}, 0);
        step(0, 8'h00, 0, 0, 0, 0);
        idle(10, 1);

        // held rx_done
        for (int i = 0; i < 4; i++) step(1, 8'h77, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("held_level", 32'(level), 1);
        idle(2, 1);

        // reset mid-operation with dirty state
        for (int i = 0; i < 3; i++) frame(8'h40 + 8'(i), 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0, 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        frame(8'h5A, 0, 0);
        chk("rst_tag", {31'd0, m_frame_err}, 0);
        idle(2, 1);

        // error frame (stored or discarded depending on build)
        frame(8'h99, 1, 0);
        chk("99_cnt", 32'(err_cnt), 1);
        idle(2, 1);

        // counter saturation
        for (int i = 0; i < 300; i++) frame(8'(i), 1, 1);
        chk("sat_cnt", 32'(err_cnt), 255);
        idle(10, 1);
        step(0, 8'h00, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 2) == 0), 8'($urandom()),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
